ex_stage: RTL and testbench

Execute stage of the five-stage CPU pipeline. It sits directly downstream of the ID/EX pipeline register and consumes its EX_* outputs. It performs the ALU operation, holds the N/C/V/Z flag register, and resolves branches against the committed flags. Its results feed the EX/MEM pipeline register; its stall and branch outputs return to hazard control.

---
 rtl/ex_stage.sv | 188 ++++++++++++++++++
 tb/tb_ex_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage: ALU, N/C/V/Z flag register, branch resolution.
// Define EX_MUL_EN to turn opcode 7 into an iterative 32x32 MUL.
module ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_in,
    input  logic        hlt,
    input  logic        flush_in,
    input  logic [21:0] EX_PC_out,
    input  logic [31:0] EX_s_data,
    input  logic [31:0] EX_t_data,
    input  logic        EX_use_imm,
    input  logic [16:0] EX_imm,
    input  logic [2:0]  EX_alu_opcode,
    input  logic        EX_update_neg,
    input  logic        EX_update_carry,
    input  logic        EX_update_ov,
    input  logic        EX_update_zero,
    input  logic [2:0]  EX_branch_conditions,
    output logic [31:0] ex_result,
    output logic        ex_flag_n,
    output logic        ex_flag_c,
    output logic        ex_flag_v,
    output logic        ex_flag_z,
    output logic        ex_branch_taken,
    output logic [21:0] ex_branch_target,
    output logic        ex_stall
);

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [32:0] add_w;
    logic [32:0] sub_w;
    logic [4:0]  shamt;
    logic        c_new;
    logic        v_new;
    logic        wq;
    logic        cond;

`ifdef EX_MUL_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

    mul_state_t  state;
    logic [31:0] mc_a;
    logic [31:0] mc_b;
    logic [31:0] prod;
    logic [1:0]  cnt;
    logic [1:0]  idx;
    logic [7:0]  b_byte;
    logic [31:0] pp;
    logic        is_mul;
    logic        hold;

    assign is_mul = (EX_alu_opcode == 3'd7);
    assign hold   = stall_in | hlt;
    assign idx    = cnt + 2'd1;
    assign b_byte = mc_b[{idx, 3'b000} +: 8];
    assign pp     = (mc_a * {24'b0, b_byte}) << {idx, 3'b000};

    // Busy from the cycle a MUL is first seen until its product is ready.
    assign ex_stall = (state == BUSY) |
                      ((state == IDLE) & is_mul & !flush_in);

    // Multiplier FSM: byte 0 on load, bytes 1..3 in BUSY, then DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 2'd0;
            mc_a  <= '0;
            mc_b  <= '0;
            prod  <= '0;
        end else if (flush_in) begin
            state <= IDLE;
            cnt   <= 2'd0;
            prod  <= '0;
        end else if (!hold) begin
            unique case (state)
                IDLE: begin
                    if (is_mul) begin
                        mc_a  <= op_a;
                        mc_b  <= op_b;
                        prod  <= op_a * {24'b0, op_b[7:0]};
                        cnt   <= 2'd0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    prod <= prod + pp;
                    cnt  <= cnt + 2'd1;
                    if (cnt == 2'd2)
                        state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign ex_stall = 1'b0;
`endif

    assign op_a  = EX_s_data;
    assign add_w = {1'b0, op_a} + {1'b0, op_b};
    assign sub_w = {1'b0, op_a} - {1'b0, op_b};
    assign shamt = op_b[4:0];

    // Operand B: register or sign-extended immediate.
    always_comb begin
        op_b = EX_t_data;
        if (EX_use_imm)
            op_b = {{15{EX_imm[16]}}, EX_imm};
    end

    // ALU result plus carry/overflow candidates.
    always_comb begin
        ex_result = add_w[31:0];
        c_new     = 1'b0;
        v_new     = 1'b0;
        unique case (EX_alu_opcode)
            3'd0: begin
                ex_result = add_w[31:0];
                c_new     = add_w[32];
                v_new     = (op_a[31] == op_b[31]) &
                            (add_w[31] != op_a[31]);
            end
            3'd1: begin
                ex_result = sub_w[31:0];
                c_new     = !sub_w[32];
                v_new     = (op_a[31] != op_b[31]) &
                            (sub_w[31] != op_a[31]);
            end
            3'd2: ex_result = op_a & op_b;
            3'd3: ex_result = op_a | op_b;
            3'd4: ex_result = op_a ^ op_b;
            3'd5: ex_result = op_a << shamt;
            3'd6: ex_result = op_a >> shamt;
`ifdef EX_MUL_EN
            3'd7: ex_result = prod;
`else
            3'd7: ex_result = $signed(op_a) >>> shamt;
`endif
            default: ex_result = add_w[31:0];
        endcase
    end

    assign wq = !stall_in & !hlt & !flush_in & !ex_stall;

    // Flag register: per-flag enables, gated by the write qualifier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_flag_n <= 1'b0;
            ex_flag_c <= 1'b0;
            ex_flag_v <= 1'b0;
            ex_flag_z <= 1'b0;
        end else if (wq) begin
            if (EX_update_neg)
                ex_flag_n <= ex_result[31];
            if (EX_update_carry)
                ex_flag_c <= c_new;
            if (EX_update_ov)
                ex_flag_v <= v_new;
            if (EX_update_zero)
                ex_flag_z <= (ex_result == 32'd0);
        end
    end

    // Branch condition on the committed flags.
    always_comb begin
        cond = 1'b0;
        unique case (EX_branch_conditions)
            3'd0: cond = 1'b0;
            3'd1: cond = ex_flag_z;
            3'd2: cond = !ex_flag_z;
            3'd3: cond = !ex_flag_z & !ex_flag_n;
            3'd4: cond = ex_flag_n;
            3'd5: cond = !ex_flag_n;
            3'd6: cond = ex_flag_n | ex_flag_z;
            3'd7: cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    assign ex_branch_taken = cond & (EX_branch_conditions != 3'd0) &
                             !stall_in & !hlt & !flush_in;

    assign ex_branch_target = EX_PC_out + {{5{EX_imm[16]}}, EX_imm};

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU, flags, branches, stalls,
// and the iterative multiplier when EX_MUL_EN is defined.
module tb_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        stall_in;
    logic        hlt;
    logic        flush_in;
    logic [21:0] EX_PC_out;
    logic [31:0] EX_s_data;
    logic [31:0] EX_t_data;
    logic        EX_use_imm;
    logic [16:0] EX_imm;
    logic [2:0]  EX_alu_opcode;
    logic        EX_update_neg;
    logic        EX_update_carry;
    logic        EX_update_ov;
    logic        EX_update_zero;
    logic [2:0]  EX_branch_conditions;
    logic [31:0] ex_result;
    logic        ex_flag_n;
    logic        ex_flag_c;
    logic        ex_flag_v;
    logic        ex_flag_z;
    logic        ex_branch_taken;
    logic [21:0] ex_branch_target;
    logic        ex_stall;

    int n_cmp = 0;
    int n_err = 0;

    ex_stage dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .stall_in             (stall_in),
        .hlt                  (hlt),
        .flush_in             (flush_in),
        .EX_PC_out            (EX_PC_out),
        .EX_s_data            (EX_s_data),
        .EX_t_data            (EX_t_data),
        .EX_use_imm           (EX_use_imm),
        .EX_imm               (EX_imm),
        .EX_alu_opcode        (EX_alu_opcode),
        .EX_update_neg        (EX_update_neg),
        .EX_update_carry      (EX_update_carry),
        .EX_update_ov         (EX_update_ov),
        .EX_update_zero       (EX_update_zero),
        .EX_branch_conditions (EX_branch_conditions),
        .ex_result            (ex_result),
        .ex_flag_n            (ex_flag_n),
        .ex_flag_c            (ex_flag_c),
        .ex_flag_v            (ex_flag_v),
        .ex_flag_z            (ex_flag_z),
        .ex_branch_taken      (ex_branch_taken),
        .ex_branch_target     (ex_branch_target),
        .ex_stall             (ex_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic n,
                             input logic c, input logic v, input logic z);
        chk({tag, ".n"}, {31'b0, ex_flag_n}, {31'b0, n});
        chk({tag, ".c"}, {31'b0, ex_flag_c}, {31'b0, c});
        chk({tag, ".v"}, {31'b0, ex_flag_v}, {31'b0, v});
        chk({tag, ".z"}, {31'b0, ex_flag_z}, {31'b0, z});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        stall_in = 0; hlt = 0; flush_in = 0;
        EX_PC_out = '0; EX_s_data = '0; EX_t_data = '0;
        EX_use_imm = 0; EX_imm = '0; EX_alu_opcode = '0;
        EX_update_neg = 0; EX_update_carry = 0;
        EX_update_ov = 0; EX_update_zero = 0;
        EX_branch_conditions = '0;
    endtask

    task automatic op(input logic [2:0] opc, input logic [31:0] a,
                      input logic [31:0] b, input logic ui,
                      input logic [16:0] imm, input logic upd);
        EX_alu_opcode = opc; EX_s_data = a; EX_t_data = b;
        EX_use_imm = ui; EX_imm = imm;
        EX_update_neg = upd; EX_update_carry = upd;
        EX_update_ov = upd; EX_update_zero = upd;
    endtask

    initial begin
        clr();
        rst_n = 0;
        #2;
        chk("rst_flag_n", {31'b0, ex_flag_n}, 32'd0);
        chk("rst_flag_z", {31'b0, ex_flag_z}, 32'd0);
        chk("rst_stall", {31'b0, ex_stall}, 32'd0);
        chk("rst_result", ex_result, 32'd0);
        #10 rst_n = 1;
        tick();

        // ADD overflow into sign bit
        op(3'd0, 32'h7FFF_FFFF, 32'd1, 0, '0, 1);
        #1 chk("add_res", ex_result, 32'h8000_0000);
        tick();
        chk_flags("add", 1, 0, 1, 0);

        // SUB 5 - imm 5
        op(3'd1, 32'd5, 32'd0, 1, 17'd5, 1);
        #1 chk("sub_res", ex_result, 32'd0);
        tick();
        chk_flags("sub", 0, 1, 0, 1);

        // Branch EQ on committed Z, negative offset
        clr();
        EX_branch_conditions = 3'd1; EX_imm = 17'h1FFFD;
        EX_PC_out = 22'h10;
        #1 chk("beq_taken", {31'b0, ex_branch_taken}, 32'd1);
        chk("beq_target", {10'b0, ex_branch_target}, 32'h0D);
        EX_branch_conditions = 3'd2;
        #1 chk("bne_taken", {31'b0, ex_branch_taken}, 32'd0);
        EX_branch_conditions = 3'd3;
        #1 chk("bgt_taken", {31'b0, ex_branch_taken}, 32'd0);
        EX_branch_conditions = 3'd4;
        #1 chk("blt_taken", {31'b0, ex_branch_taken}, 32'd0);
        EX_branch_conditions = 3'd5;
        #1 chk("bge_taken", {31'b0, ex_branch_taken}, 32'd1);
        EX_branch_conditions = 3'd6;
        #1 chk("ble_taken", {31'b0, ex_branch_taken}, 32'd1);
        EX_branch_conditions = 3'd0;
        #1 chk("bnone_taken", {31'b0, ex_branch_taken}, 32'd0);
        tick();
        chk_flags("br_noupd", 0, 1, 0, 1);

        // SUB 3-5 with branch EQ, stalled for 3 cycles
        op(3'd1, 32'd3, 32'd5, 0, 17'd4, 1);
        EX_branch_conditions = 3'd1;
        EX_PC_out = 22'h3FFFFE;
        stall_in = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stl_taken", {31'b0, ex_branch_taken}, 32'd0);
            chk("stl_res", ex_result, 32'hFFFF_FFFE);
            tick();
            chk_flags("stl_hold", 0, 1, 0, 1);
        end
        stall_in = 0;
        #1 chk("stl_rel_taken", {31'b0, ex_branch_taken}, 32'd1);
        chk("stl_rel_target", {10'b0, ex_branch_target}, 32'h2);
        tick();
        chk_flags("stl_rel", 1, 0, 0, 0);

        // hlt and flush both block flags and branches
        clr();
        op(3'd0, 32'd0, 32'd0, 0, '0, 1);
        EX_branch_conditions = 3'd7;
        hlt = 1;
        #1 chk("hlt_taken", {31'b0, ex_branch_taken}, 32'd0);
        tick();
        chk_flags("hlt_hold", 1, 0, 0, 0);
        hlt = 0; flush_in = 1; stall_in = 1;
        #1 chk("fl_taken", {31'b0, ex_branch_taken}, 32'd0);
        tick();
        chk_flags("fl_hold", 1, 0, 0, 0);
        flush_in = 0; stall_in = 0;
        #1 chk("alw_taken", {31'b0, ex_branch_taken}, 32'd1);
        tick();
        chk_flags("add0", 0, 0, 0, 1);

        // Carry out with zero result, then logic op clears C/V
        clr();
        op(3'd0, 32'hFFFF_FFFF, 32'd1, 0, '0, 1);
        #1 chk("addc_res", ex_result, 32'd0);
        tick();
        chk_flags("addc", 0, 1, 0, 1);
        op(3'd2, 32'hFFFF_FFFF, 32'hF0F0_F0F0, 0, '0, 1);
        #1 chk("and_res", ex_result, 32'hF0F0_F0F0);
        tick();
        chk_flags("and", 1, 0, 0, 0);

        op(3'd3, 32'h0F00, 32'h00F0, 0, '0, 0);
        #1 chk("or_res", ex_result, 32'h0FF0);
        op(3'd4, 32'hFF, 32'h0F, 0, '0, 0);
        #1 chk("xor_res", ex_result, 32'hF0);
        op(3'd5, 32'd1, 32'd0, 1, 17'd31, 0);
        #1 chk("sll31_res", ex_result, 32'h8000_0000);
        op(3'd6, 32'hDEAD_BEEF, 32'h20, 0, '0, 0);
        #1 chk("srl0_res", ex_result, 32'hDEAD_BEEF);
        op(3'd6, 32'h8000_0000, 32'd4, 0, '0, 0);
        #1 chk("srl4_res", ex_result, 32'h0800_0000);
        tick();

        // Negative immediate sign-extension
        op(3'd0, 32'd10, 32'd0, 1, 17'h1FFFD, 1);
        #1 chk("addneg_res", ex_result, 32'd7);
        tick();
        chk_flags("addneg", 0, 1, 0, 0);

`ifdef EX_MUL_EN
        clr();
        op(3'd7, 32'h0001_2345, 32'h100, 0, '0, 1);
        for (int i = 1; i <= 4; i++) begin
            #1 chk("mul_busy", {31'b0, ex_stall}, 32'd1);
            tick();
            chk_flags("mul_nowr", 0, 1, 0, 0);
        end
        #1 chk("mul_done_stall", {31'b0, ex_stall}, 32'd0);
        chk("mul_res", ex_result, 32'h0123_4500);
        tick();
        clr();
        chk_flags("mul_flags", 0, 0, 0, 0);
        #1 chk("mul_idle", {31'b0, ex_stall}, 32'd0);

        op(3'd1, 32'd5, 32'd5, 0, '0, 1);
        tick();
        chk_flags("pre_fl", 0, 1, 0, 1);
        op(3'd7, 32'h0001_2345, 32'h100, 0, '0, 1);
        tick();
        tick();
        flush_in = 1;
        #1 chk("mulfl_busy", {31'b0, ex_stall}, 32'd1);
        tick();
        clr();
        #1 chk("mulfl_idle", {31'b0, ex_stall}, 32'd0);
        tick();
        chk_flags("mulfl", 0, 1, 0, 1);

        op(3'd7, 32'd3, 32'd3, 0, '0, 1);
        tick();
        tick();
        #2 rst_n = 0;
        clr();
        #1 chk("rstmid_stall", {31'b0, ex_stall}, 32'd0);
`else
        clr();
        op(3'd7, 32'h8000_0010, 32'd4, 0, '0, 1);
        #1 chk("sra_res", ex_result, 32'hF800_0001);
        chk("sra_stall", {31'b0, ex_stall}, 32'd0);
        tick();
        chk_flags("sra", 1, 0, 0, 0);
        chk("sra_stall2", {31'b0, ex_stall}, 32'd0);
        op(3'd0, 32'd1, 32'd1, 0, '0, 1);
        tick();
        chk_flags("pre_rst", 0, 0, 0, 0);
        op(3'd0, 32'hFFFF_FFFF, 32'd2, 0, '0, 1);
        tick();
        chk_flags("pre_rst2", 0, 1, 0, 0);
        #2 rst_n = 0;
        #1 chk("rstmid_stall", {31'b0, ex_stall}, 32'd0);
`endif
        chk_flags("rstmid", 0, 0, 0, 0);
        tick();
        rst_n = 1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
